// File: rtl/data_plexer_sched.sv
// Round-robin burst scheduler driving the data plexer's lane select.
// Holds a grant for up to BURST_LEN accepted beats, then rotates priority past the released lane.
module data_plexer_sched #(
  parameter int unsigned SEL       = 1,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2**SEL-1:0]   req,
  input  logic                out_ready,
  output logic [SEL-1:0]      sel_ctrl,
  output logic [2**SEL-1:0]   grant,
  output logic                out_valid,
  output logic                last_beat
);

  localparam int unsigned Lanes = 2 ** SEL;
  localparam int unsigned CntW  = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BURST_LEN - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [SEL-1:0]   ptr_q, ptr_d;
  logic [SEL-1:0]   sel_q, sel_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Lanes-1:0] grant_q, grant_d;
  logic [SEL-1:0]   next_ptr;
  logic [SEL:0]     pick_idle, pick_next;

  // Returns {found, lane}: first requesting lane at or after base, wrapping.
  function automatic logic [SEL:0] pick_lane(input logic [Lanes-1:0] r,
                                             input logic [SEL-1:0]   base);
    logic [SEL:0]   res;
    logic [SEL-1:0] idx;
    res = '0;
    for (int k = Lanes - 1; k >= 0; k--) begin
      idx = base + SEL'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign next_ptr  = sel_q + 1'b1;
  assign pick_idle = pick_lane(req, ptr_q);
  assign pick_next = pick_lane(req, next_ptr);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_idle[SEL]) begin
          state_d = StGrant;
          sel_d   = pick_idle[SEL-1:0];
          grant_d = Lanes'(1) << pick_idle[SEL-1:0];
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (out_ready) begin
          if (cnt_q != CntMax && req[sel_q]) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Grant ends: released lane drops to lowest priority.
            ptr_d = next_ptr;
            cnt_d = '0;
            if (pick_next[SEL]) begin
              sel_d   = pick_next[SEL-1:0];
              grant_d = Lanes'(1) << pick_next[SEL-1:0];
            end else begin
              state_d = StIdle;
              grant_d = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign sel_ctrl  = sel_q;
  assign grant     = grant_q;
  assign out_valid = (state_q == StGrant);
  assign last_beat = out_valid && (cnt_q == CntMax);

endmodule

// File: tb/tb_data_plexer_sched.sv
// Bench for data_plexer_sched: a lane-ownership model predicts each cycle's outputs into a queue,
// and an independent monitor compares the DUT outputs against the queued expectations.
module tb_data_plexer_sched;

  localparam int unsigned SEL = 2;
  localparam int unsigned BL  = 4;
  localparam int unsigned N   = 2 ** SEL;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '1;
  logic           out_ready = 1'b0;
  logic [SEL-1:0] sel_ctrl;
  logic [N-1:0]   grant;
  logic           out_valid;
  logic           last_beat;

  data_plexer_sched #(
    .SEL      (SEL),
    .BURST_LEN(BL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .out_ready(out_ready),
    .sel_ctrl (sel_ctrl),
    .grant    (grant),
    .out_valid(out_valid),
    .last_beat(last_beat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           valid;
    logic [SEL-1:0] sel;
    logic [N-1:0]   grant;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   run = 1'b1;

  // Model state: which lane owns the output (-1 = nobody), beats already accepted, priority start.
  int owner    = -1;
  int beats    = 0;
  int ptr      = 0;
  int last_sel = 0;

  function automatic int model_pick(input logic [N-1:0] r, input int base);
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      exp_t e;
      int   lane;
      e.valid = (owner >= 0);
      e.sel   = SEL'(last_sel);
      e.grant = e.valid ? (N'(1) << last_sel) : '0;
      e.last  = e.valid && (beats == BL - 1);
      exp_q.push_back(e);
      if (rst) begin
        owner = -1; beats = 0; ptr = 0; last_sel = 0;
      end else if (owner < 0) begin
        lane = model_pick(req, ptr);
        if (lane >= 0) begin
          owner = lane; last_sel = lane; beats = 0;
        end
      end else if (out_ready) begin
        if (beats < BL - 1 && req[owner]) begin
          beats++;
        end else begin
          ptr  = (owner + 1) % N;
          lane = model_pick(req, ptr);
          beats = 0;
          if (lane >= 0) begin
            owner = lane; last_sel = lane;
          end else begin
            owner = -1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (run) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard at %0t: got empty queue, required an entry", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_valid", int'(out_valid), int'(e.valid));
        check("sel_ctrl", int'(sel_ctrl), int'(e.sel));
        check("grant", int'(grant), int'(e.grant));
        check("last_beat", int'(last_beat), int'(e.last));
      end
    end
  end

  task automatic cyc(input logic r, input logic [N-1:0] q, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      rst = r;
      req = q;
      out_ready = rdy;
    end
  endtask

  initial begin
    logic [N-1:0] rq;
    // Reset held with all lanes requesting, then release.
    cyc(1'b1, '1, 1'b1, 1);
    cyc(1'b0, 4'b0011, 1'b1, 20);
    // Owner drops request on its 2nd transfer.
    cyc(1'b0, 4'b0000, 1'b0, 3);
    cyc(1'b0, 4'b0001, 1'b1, 2);
    cyc(1'b0, 4'b0000, 1'b1, 3);
    // Stall after beat 1 with request dropped during the stall.
    cyc(1'b0, 4'b0010, 1'b1, 2);
    cyc(1'b0, 4'b0010, 1'b0, 2);
    cyc(1'b0, 4'b0000, 1'b0, 3);
    cyc(1'b0, 4'b0000, 1'b1, 3);
    // Lane 2 released, pointer wraps past lane 3 to lane 0, then lane 2.
    cyc(1'b0, 4'b0100, 1'b1, 2);
    cyc(1'b0, 4'b0000, 1'b1, 2);
    cyc(1'b0, 4'b0101, 1'b1, 10);
    // Reset during a burst, then lanes 0 and 1 compete.
    cyc(1'b0, 4'b0000, 1'b1, 3);
    cyc(1'b0, 4'b1000, 1'b1, 2);
    cyc(1'b1, 4'b0011, 1'b1, 1);
    cyc(1'b0, 4'b0011, 1'b1, 6);
    // Randomized traffic with sticky requests and random backpressure.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) rq = N'($urandom);
      cyc(($urandom_range(299) == 0), rq, ($urandom_range(3) != 0), 1);
    end
    cyc(1'b0, 4'b0000, 1'b1, 3);
    run = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
